// File: rtl/amm_arb_pkg.sv
// Shared types and defaults for the two-master Avalon-MM arbiter.
// Imported by the arbiter top and its pending-ID FIFO.
package amm_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic master_id_t;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned MAX_PEND_DEF = 4;

    // Round-robin pick: on contention the master not granted last wins.
    function automatic master_id_t rr_pick(
        input logic       elig0,
        input logic       elig1,
        input master_id_t last
    );
        master_id_t pick;
        if (elig0 && elig1) begin
            pick = ~last;
        end else if (elig1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/amm_arb_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads.
// Push and pop may coincide; pointers wrap on a power-of-two depth.
module amm_arb_id_fifo
    import amm_arb_pkg::*;
#(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = MAX_PEND_DEF,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // Next-state: a push while full is only honoured if a pop frees a slot.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset empties the queue.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/amm_arbiter_2x1.sv
// Two-master round-robin arbiter onto one pipelined Avalon-MM slave.
// Read responses are routed back in order through a pending-ID FIFO.
module amm_arbiter_2x1
    import amm_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [DATA_W-1:0]   s_writedata,
    output logic                s_read,
    output logic                s_write,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid
);

    state_t     state_q, state_d;
    master_id_t owner_q, owner_d;
    master_id_t last_q, last_d;
    logic       err_q, err_d;

    logic       elig0;
    logic       elig1;
    logic       own_rd;
    logic       own_wr;
    logic       accept;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    master_id_t head_id;

    assign elig0  = m0_write || (m0_read && !fifo_full);
    assign elig1  = m1_write || (m1_read && !fifo_full);
    assign own_rd = owner_q ? m1_read  : m0_read;
    assign own_wr = owner_q ? m1_write : m0_write;

    assign accept = (state_q == BUSY) && (s_read || s_write)
                    && !s_waitrequest;
    assign push   = accept && s_read;
    assign pop    = s_readdatavalid && !fifo_empty;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop && (head_id == 1'b0);
    assign m1_readdatavalid = pop && (head_id == 1'b1);

    // Next-state: grant in IDLE, release on acceptance or withdrawn strobes.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q || (s_readdatavalid && fifo_empty);
        unique case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    owner_d = rr_pick(elig0, elig1, last_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (!own_rd && !own_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux and master stalls; only the owner in BUSY sees the slave.
    always_comb begin
        s_address      = '0;
        s_byteenable   = '0;
        s_writedata    = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (state_q == BUSY) begin
            s_read  = own_rd;
            s_write = own_wr;
            if (owner_q == 1'b0) begin
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest;
            end else begin
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest;
            end
        end
    end

    // Control registers; last grant resets to m1 so m0 wins first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    amm_arb_id_fifo #(
        .W     (1),
        .DEPTH (MAX_PEND)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (owner_q),
        .pop_i   (pop),
        .dout_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_amm_arbiter_2x1.sv
// Directed bench for amm_arbiter_2x1.
// Event codes in the grant log: 0/1 = accept by m0/m1, 2 = idle, 3 = other.
module tb_amm_arbiter_2x1;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [31:0] s_address;
    logic [3:0]  s_byteenable;
    logic [31:0] s_writedata;
    logic        s_read, s_write;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;

    int          n_chk;
    int          n_pass;
    logic [31:0] ev [64];
    int          ev_n;

    amm_arbiter_2x1 dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_byteenable     (s_byteenable),
        .s_writedata      (s_writedata),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_read         = 1'b0;
        m0_write        = 1'b0;
        m1_read         = 1'b0;
        m1_write        = 1'b0;
        s_waitrequest   = 1'b0;
        s_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Both masters stream n0/n1 commands; log one event per cycle.
    task automatic run_cmds(
        input int   n0,
        input int   n1,
        input logic rd0,
        input logic rd1
    );
        int   c0;
        int   c1;
        int   cyc;
        logic acc0;
        logic acc1;
        c0   = 0;
        c1   = 0;
        cyc  = 0;
        ev_n = 0;
        @(negedge clk_i);
        m0_address   = 32'h100;
        m1_address   = 32'h200;
        m0_writedata = 32'h0000_AAAA;
        m1_writedata = 32'h0000_BBBB;
        m0_read      = (n0 > 0) && rd0;
        m0_write     = (n0 > 0) && !rd0;
        m1_read      = (n1 > 0) && rd1;
        m1_write     = (n1 > 0) && !rd1;
        while ((c0 < n0 || c1 < n1) && cyc < 40) begin
            #1;
            acc0 = (s_read || s_write) && !s_waitrequest && !m0_waitrequest;
            acc1 = (s_read || s_write) && !s_waitrequest && !m1_waitrequest;
            if (ev_n < 64) begin
                if (acc0)                   ev[ev_n] = 32'd0;
                else if (acc1)              ev[ev_n] = 32'd1;
                else if (!s_read && !s_write) ev[ev_n] = 32'd2;
                else                        ev[ev_n] = 32'd3;
            end
            ev_n++;
            @(posedge clk_i);
            #1;
            if (acc0) begin
                c0++;
                if (c0 == n0) begin
                    m0_read  = 1'b0;
                    m0_write = 1'b0;
                end
            end
            if (acc1) begin
                c1++;
                if (c1 == n1) begin
                    m1_read  = 1'b0;
                    m1_write = 1'b0;
                end
            end
            @(negedge clk_i);
            cyc++;
        end
        chk("run_acc0", c0, n0);
        chk("run_acc1", c1, n1);
    endtask

    // Expected log for alternating grants starting at m0: idle, grant, ...
    task automatic check_alt(input string tag, input int n);
        logic [31:0] exp_ev;
        chk("log_len", ev_n, n);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0)            exp_ev = 32'd2;
            else if ((i / 2) % 2 == 0) exp_ev = 32'd0;
            else                       exp_ev = 32'd1;
            chk(tag, ev[i], exp_ev);
        end
    endtask

    task automatic resp(input int id, input logic [31:0] data);
        @(negedge clk_i);
        s_readdatavalid = 1'b1;
        s_readdata      = data;
        #1;
        chk("rsp_m0_rdv", 32'(m0_readdatavalid), 32'(id == 0));
        chk("rsp_m1_rdv", 32'(m1_readdatavalid), 32'(id == 1));
        chk("rsp_m0_data", m0_readdata, data);
        chk("rsp_m1_data", m1_readdata, data);
        @(posedge clk_i);
        #1;
        s_readdatavalid = 1'b0;
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst_i         = 1'b0;
        m0_address    = '0;
        m1_address    = '0;
        m0_byteenable = 4'hF;
        m1_byteenable = 4'h3;
        m0_writedata  = '0;
        m1_writedata  = '0;
        s_readdata    = '0;
        idle_inputs();

        // Reset values
        #1;
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 1);
        chk("rst_s_read", 32'(s_read), 0);
        chk("rst_s_write", 32'(s_write), 0);
        chk("rst_m0_rdv", 32'(m0_readdatavalid), 0);
        chk("rst_err", 32'(dut.err_q), 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Single write from m0
        @(negedge clk_i);
        m0_write      = 1'b1;
        m0_address    = 32'h10;
        m0_writedata  = 32'hA5A5_A5A5;
        m0_byteenable = 4'hF;
        #1;
        chk("w_idle_swrite", 32'(s_write), 0);
        chk("w_idle_m0_wait", 32'(m0_waitrequest), 1);
        @(negedge clk_i);
        #1;
        chk("w_busy_swrite", 32'(s_write), 1);
        chk("w_busy_addr", s_address, 32'h10);
        chk("w_busy_data", s_writedata, 32'hA5A5_A5A5);
        chk("w_busy_be", 32'(s_byteenable), 32'hF);
        chk("w_busy_m0_wait", 32'(m0_waitrequest), 0);
        chk("w_busy_m1_wait", 32'(m1_waitrequest), 1);
        @(posedge clk_i);
        #1;
        m0_write = 1'b0;
        @(negedge clk_i);
        #1;
        chk("w_after_swrite", 32'(s_write), 0);
        chk("w_after_m1_wait", 32'(m1_waitrequest), 1);

        // Contending writes, fresh reset so m0 has priority
        do_reset();
        run_cmds(4, 4, 1'b0, 1'b0);
        check_alt("rr_write_log", 16);

        // m1 read with 3 stall cycles, response two cycles after acceptance
        @(negedge clk_i);
        m1_read       = 1'b1;
        m1_address    = 32'h40;
        s_waitrequest = 1'b1;
        #1;
        chk("r_idle_m1_wait", 32'(m1_waitrequest), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            chk("r_stall_sread", 32'(s_read), 1);
            chk("r_stall_m1_wait", 32'(m1_waitrequest), 1);
            chk("r_stall_addr", s_address, 32'h40);
        end
        @(negedge clk_i);
        s_waitrequest = 1'b0;
        #1;
        chk("r_acc_m1_wait", 32'(m1_waitrequest), 0);
        chk("r_acc_m0_wait", 32'(m0_waitrequest), 1);
        @(posedge clk_i);
        #1;
        m1_read = 1'b0;
        @(negedge clk_i);
        #1;
        chk("r_gap_m1_rdv", 32'(m1_readdatavalid), 0);
        chk("r_gap_sread", 32'(s_read), 0);
        resp(1, 32'h1234_5678);

        // Four interleaved reads fill the FIFO
        run_cmds(2, 2, 1'b1, 1'b1);
        check_alt("rr_read_log", 8);
        chk("full_count", 32'(dut.u_fifo.count_q), 4);

        // Fifth read from m0 stalls while full
        @(negedge clk_i);
        m0_read    = 1'b1;
        m0_address = 32'h500;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            chk("full_rd_sread", 32'(s_read), 0);
            chk("full_rd_m0_wait", 32'(m0_waitrequest), 1);
        end

        // A write from m1 still gets through
        @(negedge clk_i);
        m1_write     = 1'b1;
        m1_address   = 32'h600;
        m1_writedata = 32'hC0DE_0600;
        #1;
        chk("full_w_idle", 32'(s_write), 0);
        @(negedge clk_i);
        #1;
        chk("full_w_swrite", 32'(s_write), 1);
        chk("full_w_sread", 32'(s_read), 0);
        chk("full_w_addr", s_address, 32'h600);
        chk("full_w_m1_wait", 32'(m1_waitrequest), 0);
        chk("full_w_m0_wait", 32'(m0_waitrequest), 1);
        @(posedge clk_i);
        #1;
        m1_write = 1'b0;
        @(negedge clk_i);
        #1;
        chk("full_post_sread", 32'(s_read), 0);
        chk("full_post_count", 32'(dut.u_fifo.count_q), 4);
        @(posedge clk_i);
        #1;
        m0_read = 1'b0;

        // Responses 1..3 route m0, m1, m0
        resp(0, 32'hD000_0001);
        resp(1, 32'hD000_0002);
        resp(0, 32'hD000_0003);
        chk("drain_count", 32'(dut.u_fifo.count_q), 1);

        // Response 4 (m1) collides with a new m0 read being accepted
        @(negedge clk_i);
        m0_read    = 1'b1;
        m0_address = 32'h700;
        #1;
        chk("col_idle_m0_wait", 32'(m0_waitrequest), 1);
        @(negedge clk_i);
        s_readdatavalid = 1'b1;
        s_readdata      = 32'hD000_0004;
        #1;
        chk("col_sread", 32'(s_read), 1);
        chk("col_m0_wait", 32'(m0_waitrequest), 0);
        chk("col_m1_rdv", 32'(m1_readdatavalid), 1);
        chk("col_m0_rdv", 32'(m0_readdatavalid), 0);
        @(posedge clk_i);
        #1;
        m0_read         = 1'b0;
        s_readdatavalid = 1'b0;
        @(negedge clk_i);
        #1;
        chk("col_count", 32'(dut.u_fifo.count_q), 1);
        resp(0, 32'hD000_0005);
        chk("empty_count", 32'(dut.u_fifo.count_q), 0);
        chk("no_err", 32'(dut.err_q), 0);

        // Async reset mid-BUSY with two reads pending
        run_cmds(2, 0, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(dut.u_fifo.count_q), 2);
        @(negedge clk_i);
        m0_read       = 1'b1;
        m0_address    = 32'h900;
        s_waitrequest = 1'b1;
        @(negedge clk_i);
        #1;
        chk("pre_rst_sread", 32'(s_read), 1);
        chk("pre_rst_m0_wait", 32'(m0_waitrequest), 1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_sread", 32'(s_read), 0);
        chk("arst_swrite", 32'(s_write), 0);
        chk("arst_m0_wait", 32'(m0_waitrequest), 1);
        chk("arst_m1_wait", 32'(m1_waitrequest), 1);
        chk("arst_count", 32'(dut.u_fifo.count_q), 0);
        m0_read       = 1'b0;
        s_waitrequest = 1'b0;
        rst_i         = 1'b1;

        // Late response after reset is dropped and flagged
        @(negedge clk_i);
        s_readdatavalid = 1'b1;
        s_readdata      = 32'hDEAD_BEEF;
        #1;
        chk("late_m0_rdv", 32'(m0_readdatavalid), 0);
        chk("late_m1_rdv", 32'(m1_readdatavalid), 0);
        chk("late_err_pre", 32'(dut.err_q), 0);
        @(posedge clk_i);
        #1;
        s_readdatavalid = 1'b0;
        chk("late_err_set", 32'(dut.err_q), 1);
        @(negedge clk_i);
        #1;
        chk("late_err_sticky", 32'(dut.err_q), 1);

        do_reset();
        #1;
        chk("final_err_clr", 32'(dut.err_q), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/amm_arbiter_2x1.md
AMM_ARBITER_2X1 -- requirements
Module: amm_arbiter_2x1

Interface
- REQ-001 The block SHALL take these parameters, one per line:
  - ADDR_W, 32, address width.
  - DATA_W, 32, data width.
  - MAX_PEND, 4, outstanding-read depth (power of two, minimum 2).
- REQ-002 The block SHALL have these ports, one per line:
  - clk_i  input  1  single clock.
  - rst_i  input  1  asynchronous reset, active-low.
  - mN_address  input  ADDR_W  master N address (N = 0, 1).
  - mN_byteenable  input  DATA_W/8  master N byte enables.
  - mN_read / mN_write  input  1  master N command strobes.
  - mN_writedata  input  DATA_W  master N write data.
  - mN_waitrequest  output  1  master N stall.
  - mN_readdata  output  DATA_W  master N read data.
  - mN_readdatavalid  output  1  master N read response.
  - s_address / s_byteenable / s_writedata  output  ADDR_W / DATA_W/8 / DATA_W  to slave.
  - s_read / s_write  output  1  to slave.
  - s_waitrequest  input  1  from slave.
  - s_readdata  input  DATA_W  from slave.
  - s_readdatavalid  input  1  from slave.

Function
- REQ-003 Shares one pipelined Avalon-MM slave between two masters (m0, m1).
- REQ-004 FSM states: IDLE and BUSY.
- REQ-005 In IDLE, a master is eligible when its read or write is high; a read is eligible only if the pending FIFO is not full.
- REQ-006 Arbitration is round-robin. Priority goes to the master not granted last; after reset, m0 has priority.
- REQ-007 On IDLE with at least one eligible master, the owner is registered and the FSM moves to BUSY on the next edge.
- REQ-008 In BUSY, the owner's address, byteenable, writedata, read and write drive s_* combinationally.
- REQ-009 In BUSY, owner waitrequest = s_waitrequest; the non-owner waitrequest = 1.
- REQ-010 In IDLE, both mN_waitrequest = 1, and s_read = s_write = 0.
- REQ-011 Command acceptance = BUSY & (s_read | s_write) & !s_waitrequest. On acceptance: last-grant pointer := owner, FSM := IDLE.
- REQ-012 Arbitration overhead is one IDLE cycle between accepted commands; command latency is therefore ≥ 2 cycles from strobe to acceptance.
- REQ-013 If the owner deasserts both strobes while in BUSY (protocol violation), the FSM returns to IDLE without acceptance.
- REQ-014 An accepted read pushes the owner ID into the in-order pending FIFO (depth MAX_PEND).
- REQ-015 s_readdatavalid pops the FIFO head. It drives mHEAD_readdatavalid = 1 for that cycle; the other master's readdatavalid = 0.
- REQ-016 mN_readdata = s_readdata for both masters, unconditionally.
- REQ-017 A push and pop in the same cycle is legal: the count is unchanged and the pointers wrap modulo MAX_PEND.
- REQ-018 s_readdatavalid with an empty FIFO is dropped. A sticky error flag (internal, visible to the bench) is set.
- REQ-019 With the FIFO full, a pending write from either master is still granted; pending reads wait.
- REQ-020 Writes produce no response and do not touch the FIFO.

Reset
- REQ-021 rst_i low asynchronously forces:
  - FSM = IDLE, owner = 0, last-grant pointer = 1 (so m0 wins first);
  - FIFO empty, error flag cleared;
  - mN_waitrequest = 1, mN_readdatavalid = 0, s_read = s_write = 0.
- REQ-022 Reset mid-transaction discards all pending read routing. Responses arriving after reset are treated per REQ-018.
- REQ-023 Release of rst_i takes effect on the first rising clk_i edge with rst_i high.

Structure
- REQ-024 A shared package amm_arb_pkg holds:
  - typedef state_t {IDLE, BUSY};
  - typedef master_id_t (1 bit);
  - default parameter constants.
- REQ-025 The pending FIFO is a sub-module amm_arb_id_fifo (parameterised width/depth, push/pop/full/empty). All other logic sits in amm_arbiter_2x1.

Verification
- REQ-026 Scenario: m0 writes addr 0x10, data 0xA5A5_A5A5; slave waitrequest low. Required response:
  - s_write = 1 for exactly one cycle with those values;
  - m0_waitrequest low in that cycle;
  - m1_waitrequest high throughout.
- REQ-027 Scenario: m0 and m1 both assert write continuously for 4 commands each. Required response:
  - grants alternate m0, m1, m0, m1 ...;
  - each accepted command is followed by one idle cycle.
- REQ-028 Scenario: m1 reads addr 0x40; slave holds waitrequest 3 cycles, then returns readdata 0x1234_5678 two cycles after acceptance. Required response:
  - m1_readdatavalid = 1 with 0x1234_5678;
  - m0_readdatavalid stays 0.
- REQ-029 Scenario: 4 interleaved reads (m0, m1, m0, m1) issued with the slave withholding readdatavalid. Required response:
  - a 5th read from m0 stalls (no grant);
  - a write from m1 is still accepted;
  - the 4 responses route in order m0, m1, m0, m1;
  - a push/pop collision on the 4th response keeps the count correct.
- REQ-030 Scenario: rst_i pulsed low while m0 is in BUSY with 2 reads pending. Required response:
  - all outputs return to reset values immediately (without a clock edge);
  - a late s_readdatavalid sets the error flag and asserts no mN_readdatavalid.
